// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execute-stage controller: FSM states, decode
// constants, condition codes and NZCV flag bit positions.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_MULTI  = 2'd2,
        ST_BRANCH = 2'd3
    } state_t;

    localparam logic [1:0] FLD_BRANCH = 2'b11;
    localparam logic [1:0] FLD_MUL    = 2'b00;
    localparam logic [2:0] ALU_MUL    = 3'b111;

    localparam logic [3:0] CC_AL = 4'd0;
    localparam logic [3:0] CC_EQ = 4'd1;
    localparam logic [3:0] CC_NE = 4'd2;
    localparam logic [3:0] CC_LT = 4'd3;
    localparam logic [3:0] CC_GE = 4'd4;
    localparam logic [3:0] CC_CS = 4'd5;
    localparam logic [3:0] CC_CC = 4'd6;
    localparam logic [3:0] CC_MI = 4'd7;
    localparam logic [3:0] CC_PL = 4'd8;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic state_t decode_next(input logic [1:0] fld, input logic [2:0] alu);
        if (fld == FLD_BRANCH)
            return ST_BRANCH;
        else if (fld == FLD_MUL && alu == ALU_MUL)
            return ST_MULTI;
        else
            return ST_EXEC;
    endfunction

endpackage

// File: rtl/exec_ctrl_cond.sv
// Branch condition evaluator: maps a 4-bit condition code and the NZCV
// flags to a taken/not-taken decision. Codes 9..15 are never taken.
module cond_eval
    import exec_ctrl_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] code,
    output logic       take
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        take = 1'b0;
        case (code)
            CC_AL:   take = 1'b1;
            CC_EQ:   take = z;
            CC_NE:   take = ~z;
            CC_LT:   take = n ^ v;
            CC_GE:   take = ~(n ^ v);
            CC_CS:   take = c;
            CC_CC:   take = ~c;
            CC_MI:   take = n;
            CC_PL:   take = ~n;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage controller: single-cycle ALU ops, fixed-latency multiply,
// and one-cycle branch resolution against the architectural NZCV register.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] first_level_decode,
    input  logic [3:0] second_level_decode,
    input  logic [2:0] alu_functions,
    input  logic [3:0] branch_instruction,
    input  logic [3:0] alu_flags,
    output logic       alu_en,
    output logic [1:0] op_first,
    output logic [3:0] op_second,
    output logic [2:0] op_alu,
    output logic       op_done,
    output logic       branch_taken,
    output logic       flush,
    output logic       busy,
    output logic [3:0] flags_out
);

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] op_cond;
    logic       accept;
    logic       take;

    assign in_ready = (state == ST_IDLE) || (state == ST_EXEC) ||
                      (state == ST_MULTI && cnt == '0);
    assign accept   = in_valid && in_ready;

    assign alu_en       = (state == ST_EXEC) || (state == ST_MULTI);
    assign op_done      = (state == ST_EXEC) || (state == ST_BRANCH) ||
                          (state == ST_MULTI && cnt == '0);
    assign branch_taken = (state == ST_BRANCH) && take;
    assign flush        = (state == ST_BRANCH) && take;
    assign busy         = (state != ST_IDLE);

    // Flags seen here are already updated by an ALU op retiring on the accept edge.
    cond_eval u_cond (
        .flags (flags_out),
        .code  (op_cond),
        .take  (take)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            flags_out <= '0;
            op_first  <= '0;
            op_second <= '0;
            op_alu    <= '0;
            op_cond   <= '0;
        end else begin
            if (alu_en && op_done && op_second[0])
                flags_out <= alu_flags;

            if (state == ST_MULTI && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end else if (accept) begin
                state     <= decode_next(first_level_decode, alu_functions);
                op_first  <= first_level_decode;
                op_second <= second_level_decode;
                op_alu    <= alu_functions;
                op_cond   <= branch_instruction;
                cnt       <= (first_level_decode == FLD_MUL && alu_functions == ALU_MUL)
                             ? CNT_INIT : '0;
            end else begin
                state <= ST_IDLE;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: cycle vector table with expected-output
// scoreboard, retire-field scoreboard, and hand-written reset sequences.
module tb_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] first_level_decode = '0;
    logic [3:0] second_level_decode = '0;
    logic [2:0] alu_functions = '0;
    logic [3:0] branch_instruction = '0;
    logic [3:0] alu_flags = '0;
    logic       alu_en;
    logic [1:0] op_first;
    logic [3:0] op_second;
    logic [2:0] op_alu;
    logic       op_done;
    logic       branch_taken;
    logic       flush;
    logic       busy;
    logic [3:0] flags_out;

    exec_ctrl #(.MUL_LAT(3)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .first_level_decode  (first_level_decode),
        .second_level_decode (second_level_decode),
        .alu_functions       (alu_functions),
        .branch_instruction  (branch_instruction),
        .alu_flags           (alu_flags),
        .alu_en              (alu_en),
        .op_first            (op_first),
        .op_second           (op_second),
        .op_alu              (op_alu),
        .op_done             (op_done),
        .branch_taken        (branch_taken),
        .flush               (flush),
        .busy                (busy),
        .flags_out           (flags_out)
    );

    always #5 clk = ~clk;

    // Control word order: {in_ready, alu_en, op_done, branch_taken, flush, busy}
    localparam logic [5:0] C_IDLE = 6'b100000;
    localparam logic [5:0] C_EXEC = 6'b111001;
    localparam logic [5:0] C_MBSY = 6'b010001;
    localparam logic [5:0] C_MLST = 6'b111001;
    localparam logic [5:0] C_BRT  = 6'b001111;
    localparam logic [5:0] C_BRN  = 6'b001001;

    typedef struct {
        string      name;
        logic       v;
        logic [1:0] fld;
        logic [3:0] sld;
        logic [2:0] alu;
        logic [3:0] br;
        logic [3:0] af;
        logic [5:0] ctl;
        logic [3:0] fo;
    } vec_t;

    typedef struct {
        logic [5:0] ctl;
        logic [3:0] fo;
        string      name;
    } exp_t;

    vec_t       vecs[$];
    exp_t       exp_q[$];
    logic [8:0] ret_q[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    function automatic vec_t mk(string nm, logic v, logic [1:0] fld, logic [3:0] sld,
                                logic [2:0] alu, logic [3:0] br, logic [3:0] af,
                                logic [5:0] ctl, logic [3:0] fo);
        vec_t r;
        r.name = nm; r.v = v; r.fld = fld; r.sld = sld; r.alu = alu;
        r.br = br; r.af = af; r.ctl = ctl; r.fo = fo;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic drv(input logic v, input logic [1:0] fld, input logic [3:0] sld,
                       input logic [2:0] alu, input logic [3:0] br, input logic [3:0] af);
        in_valid            = v;
        first_level_decode  = fld;
        second_level_decode = sld;
        alu_functions       = alu;
        branch_instruction  = br;
        alu_flags           = af;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] take_1000;
        exp_t        e;
        logic [8:0]  r;

        // Flags N=1,Z=0,C=0,V=0: codes 0,2,3,6,7 taken.
        take_1000 = 16'h00CD;

        vecs.push_back(mk("idle0",     0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0, C_IDLE, 4'h0));
        vecs.push_back(mk("add1_acc",  1, 2'b01, 4'h0, 3'd0, 4'd0, 4'h0, C_IDLE, 4'h0));
        vecs.push_back(mk("add2_acc",  1, 2'b01, 4'h2, 3'd1, 4'd0, 4'h0, C_EXEC, 4'h0));
        vecs.push_back(mk("add3_acc",  1, 2'b01, 4'h4, 3'd2, 4'd0, 4'h0, C_EXEC, 4'h0));
        vecs.push_back(mk("add3_exec", 0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0, C_EXEC, 4'h0));
        vecs.push_back(mk("idle1",     0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0, C_IDLE, 4'h0));
        vecs.push_back(mk("mul_acc",   1, 2'b00, 4'h0, 3'd7, 4'd0, 4'h0, C_IDLE, 4'h0));
        vecs.push_back(mk("mul_c2",    1, 2'b01, 4'h6, 3'd3, 4'd0, 4'h0, C_MBSY, 4'h0));
        vecs.push_back(mk("mul_c1",    1, 2'b01, 4'h6, 3'd3, 4'd0, 4'h0, C_MBSY, 4'h0));
        vecs.push_back(mk("mul_c0",    1, 2'b01, 4'h6, 3'd3, 4'd0, 4'h0, C_MLST, 4'h0));
        vecs.push_back(mk("post_mul",  0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0, C_EXEC, 4'h0));
        vecs.push_back(mk("idle2",     0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0, C_IDLE, 4'h0));
        vecs.push_back(mk("subs_acc",  1, 2'b01, 4'h1, 3'd1, 4'd0, 4'h0, C_IDLE, 4'h0));
        vecs.push_back(mk("beq_acc",   1, 2'b11, 4'h0, 3'd0, 4'd1, 4'h4, C_EXEC, 4'h0));
        vecs.push_back(mk("beq_br",    0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0, C_BRT,  4'h4));
        vecs.push_back(mk("idle3",     0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0, C_IDLE, 4'h4));
        vecs.push_back(mk("adds_acc",  1, 2'b01, 4'h1, 3'd0, 4'd0, 4'h0, C_IDLE, 4'h4));
        vecs.push_back(mk("bge_acc",   1, 2'b11, 4'h0, 3'd0, 4'd4, 4'h8, C_EXEC, 4'h4));
        vecs.push_back(mk("bge_br",    0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0, C_BRN,  4'h8));
        vecs.push_back(mk("idle4",     0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0, C_IDLE, 4'h8));
        vecs.push_back(mk("add_nosf",  1, 2'b01, 4'h0, 3'd0, 4'd0, 4'hF, C_IDLE, 4'h8));
        vecs.push_back(mk("nosf_exec", 0, 2'b00, 4'h0, 3'd0, 4'd0, 4'hF, C_EXEC, 4'h8));
        for (int c = 0; c < 16; c++) begin
            vecs.push_back(mk($sformatf("bcc%0d_acc", c), 1, 2'b11, 4'h0, 3'd0, c[3:0],
                              4'h0, C_IDLE, 4'h8));
            vecs.push_back(mk($sformatf("bcc%0d_br", c), 0, 2'b00, 4'h0, 3'd0, 4'd0,
                              4'h0, take_1000[c] ? C_BRT : C_BRN, 4'h8));
        end
        vecs.push_back(mk("idle_end",  0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0, C_IDLE, 4'h8));

        // Reset state: everything low except in_ready.
        #3;
        chk("rst_ctl", 16'({in_ready, alu_en, op_done, branch_taken, flush, busy}), 16'(C_IDLE));
        chk("rst_flags", 16'(flags_out), 16'h0);
        chk("rst_ops", 16'({op_first, op_second, op_alu}), 16'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drv(vecs[i].v, vecs[i].fld, vecs[i].sld, vecs[i].alu, vecs[i].br, vecs[i].af);
            e.ctl = vecs[i].ctl; e.fo = vecs[i].fo; e.name = vecs[i].name;
            exp_q.push_back(e);
            if (vecs[i].v && vecs[i].ctl[5])
                ret_q.push_back({vecs[i].fld, vecs[i].sld, vecs[i].alu});
            @(negedge clk);
            e = exp_q.pop_front();
            chk({e.name, "_ctl"},
                16'({in_ready, alu_en, op_done, branch_taken, flush, busy}), 16'(e.ctl));
            chk({e.name, "_flags"}, 16'(flags_out), 16'(e.fo));
            if (op_done) begin
                if (ret_q.size() == 0) begin
                    chk({e.name, "_unexpected_retire"}, 16'd1, 16'd0);
                end else begin
                    r = ret_q.pop_front();
                    chk({e.name, "_retire_ops"}, 16'({op_first, op_second, op_alu}), 16'(r));
                end
            end
        end
        chk("retire_q_empty", 16'(ret_q.size()), 16'd0);

        // Reset asserted asynchronously while a multiply has one cycle left.
        @(posedge clk); #1 drv(1, 2'b00, 4'h1, 3'd7, 4'd0, 4'hA);
        @(posedge clk); #1 drv(0, 2'b00, 4'h0, 3'd0, 4'd0, 4'hA);
        @(posedge clk); #1;
        chk("mmul_cnt1_ctl",
            16'({in_ready, alu_en, op_done, branch_taken, flush, busy}), 16'(C_MBSY));
        #2 rst = 1'b0;
        #1;
        chk("mmul_rst_ctl",
            16'({in_ready, alu_en, op_done, branch_taken, flush, busy}), 16'(C_IDLE));
        chk("mmul_rst_flags", 16'(flags_out), 16'h0);
        chk("mmul_rst_ops", 16'({op_first, op_second, op_alu}), 16'h0);
        @(posedge clk); #1;
        chk("mmul_hold_ctl",
            16'({in_ready, alu_en, op_done, branch_taken, flush, busy}), 16'(C_IDLE));
        chk("mmul_hold_flags", 16'(flags_out), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 drv(1, 2'b01, 4'h1, 3'd2, 4'd0, 4'h3);
        @(posedge clk); #1 drv(0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h3);
        chk("post_rst_add_ctl",
            16'({in_ready, alu_en, op_done, branch_taken, flush, busy}), 16'(C_EXEC));
        chk("post_rst_add_ops", 16'({op_first, op_second, op_alu}), 16'({2'b01, 4'h1, 3'd2}));
        @(posedge clk); #1;
        chk("post_rst_add_flags", 16'(flags_out), 16'h3);

        // Reset asserted during a taken branch cancels flush and retire.
        drv(1, 2'b11, 4'h0, 3'd0, 4'd0, 4'h0);
        @(posedge clk); #1 drv(0, 2'b00, 4'h0, 3'd0, 4'd0, 4'h0);
        chk("mbr_taken_ctl",
            16'({in_ready, alu_en, op_done, branch_taken, flush, busy}), 16'(C_BRT));
        #2 rst = 1'b0;
        #1;
        chk("mbr_rst_ctl",
            16'({in_ready, alu_en, op_done, branch_taken, flush, busy}), 16'(C_IDLE));
        chk("mbr_rst_flags", 16'(flags_out), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mbr_after_ctl",
            16'({in_ready, alu_en, op_done, branch_taken, flush, busy}), 16'(C_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 The parameter list SHALL be: MUL_LAT, default 3, cycles a multi-cycle ALU op occupies execute (legal 2..16).
REQ-002 The ports SHALL be exactly as follows, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  execute can accept this cycle.
- first_level_decode  in  2  instruction class; 2'b11 = conditional branch.
- second_level_decode  in  4  sub-opcode; bit0 = set-flags.
- alu_functions  in  3  ALU function select.
- branch_instruction  in  4  branch condition code.
- alu_flags  in  4  NZCV result from the ALU, valid while alu_en.
- alu_en  out  1  ALU operates this cycle.
- op_first, op_second, op_alu  out  2/4/3  latched fields of the instruction in flight.
- op_done  out  1  instruction retires this cycle.
- branch_taken  out  1  branch resolved taken.
- flush  out  1  discard younger fetched instructions.
- busy  out  1  state != IDLE.
- flags_out  out  4  architectural NZCV register.

Function
REQ-003 The FSM states SHALL be IDLE, EXEC, MULTI and BRANCH.
REQ-004 An accept SHALL occur when in_valid && in_ready; the instruction fields SHALL be latched into op_* on accept.
REQ-005 The accept decode SHALL be:
- first_level_decode==2'b11 -> BRANCH.
- first_level_decode==2'b00 && alu_functions==3'b111 (multiply) -> MULTI, cnt=MUL_LAT-1.
- else -> EXEC.
- No accept -> IDLE.
REQ-006 in_ready SHALL be 1 in IDLE, 1 in EXEC, 1 in MULTI only when cnt==0, and 0 in BRANCH.
REQ-007 EXEC SHALL last exactly one cycle, with alu_en=1 and op_done=1; the next state SHALL follow the REQ-005 decode (back-to-back issue).
REQ-008 MULTI SHALL assert alu_en every cycle while decrementing cnt, and SHALL assert op_done only when cnt==0; its exit SHALL follow REQ-005. Total occupancy SHALL be MUL_LAT cycles.
REQ-009 When op_done is asserted in EXEC or MULTI and latched second_level_decode[0]==1, flags_out SHALL load alu_flags at that edge.
REQ-010 BRANCH SHALL last one cycle with op_done=1 and SHALL evaluate the condition against flags_out as registered at entry; a flag write in the accept cycle SHALL therefore be visible to the branch.
REQ-011 Condition codes SHALL be: 0 always; 1 Z; 2 !Z; 3 N^V; 4 !(N^V); 5 C; 6 !C; 7 N; 8 !N; 9-15 never.
REQ-012 On a true condition, branch_taken and flush SHALL both be 1 for that single BRANCH cycle; otherwise both SHALL be 0.
REQ-013 BRANCH SHALL always exit to IDLE, giving exactly one bubble after every branch.
REQ-014 alu_en, op_done, branch_taken, flush and busy SHALL be Moore outputs decoded from registered state only.

Reset
REQ-015 While rst==0, regardless of clk, the block SHALL force: state=IDLE, cnt=0, flags_out=0, op_*=0.
REQ-016 During reset all outputs SHALL be 0 except in_ready, which SHALL be 1.
REQ-017 Reset asserted mid-MULTI or mid-BRANCH SHALL abandon the instruction with no op_done, flush or flag update.

Structure
REQ-018 The shared package exec_ctrl_pkg SHALL hold the state encoding, condition-code constants, FLD_BRANCH=2'b11 and the multiply decode constants.
REQ-019 Condition evaluation SHALL be a combinational sub-module named cond_eval (inputs: flags, code; output: take).
REQ-020 cnt SHALL be 4 bits wide.

Verification
REQ-021 Three back-to-back ADDs (fld=01, valid held high) -> op_done high on 3 consecutive cycles and in_ready never low.
REQ-022 MUL (fld=00, alu=111) with MUL_LAT=3, next instruction waiting -> alu_en high 3 cycles, op_done on the 3rd only, next accepted on that cycle.
REQ-023 SUB with set-flags producing alu_flags=4'b0100, immediately followed by BEQ (code 1) -> branch taken, flush=1 for one cycle, in_ready=0 that cycle.
REQ-024 flags_out=4'b1000 (N=1,V=0), BGE (code 4) -> branch_taken=0, flush=0, op_done=1; codes 9..15 -> never taken.
REQ-025 rst pulled low asynchronously mid-MULTI (cnt=1) -> immediate IDLE, flags_out=0, no op_done; after release, a new ADD retires normally.
